ring_link_arbiter: RTL
======================

Name: ring_link_arbiter

Overview:
- Shares one outgoing ring link between three requesters: left transit, local injection and right transit. Instantiated once per output direction in each ring node, downstream of the node routing controllers.
- Transit traffic is favoured, with round-robin between left and right. Local injection is guaranteed service through a starvation counter.
- The winning 32-bit instruction is registered onto the link with a valid/ready handshake. The tag of the source that sent it travels with the word.

Parameters:
- DATA_W, 32, instruction width.
- STARVE_LIMIT, 4, number of cycles local may wait while valid and ungranted before it is forced to win. Legal range 1..15.
- CNT_W, 16, width of each statistics counter (used only with the optional feature).

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  synchronous reset, active-high.
- req_valid  in  3  per-requester valid. Bit 0 = left transit, bit 1 = local, bit 2 = right transit.
- req_data  in  3*DATA_W  per-requester instruction. Slice i is bits [i*DATA_W +: DATA_W].
- req_ready  out  3  per-requester accept, combinational, one-hot or zero.
- out_valid  out  1  registered link valid.
- out_data  out  DATA_W  registered link instruction.
- out_src  out  2  source tag of the word on the link: 00 left, 01 local, 10 right (same encoding as source_port).
- out_ready  in  1  downstream accept.
- stat_grants  out  3*CNT_W  grant counters, zero unless LINK_ARB_STATS_EN is defined.

Behaviour:
- Reset: out_valid=0, out_data=0, out_src=00, rr_ptr=0 (left preferred), local wait counter=0, state IDLE, stat counters=0.
- Reset asserted mid-operation drops any held word with no further handshake. req_ready is 0 during any cycle reset=1.
- Slot free: slot_free = !out_valid || out_ready.
- States:
  - IDLE: out_valid=0. Go to HOLD when any grant fires.
  - HOLD: out_valid=1.
    - Stay in HOLD if out_ready=1 and a new grant fires (back-to-back, full throughput).
    - Go to IDLE if out_ready=1 and no grant fires.
    - Stay in HOLD with out_data and out_src stable if out_ready=0.
- Grant rule (evaluated only when slot_free, and only over valid requesters):
  1. If local is valid and wait_cnt >= STARVE_LIMIT, grant local.
  2. Otherwise, if one or both transits are valid, grant the transit at rr_ptr if valid, else the other valid transit.
  3. Otherwise, if local is valid, grant local.
  4. Otherwise, no grant.
- Transfer occurs on req_valid[i] && req_ready[i]. out_data and out_src load on the next rising edge, giving a latency of 1 cycle.
- rr_ptr toggles to the opposite transit only after a transit grant. Local grants leave it unchanged.
- wait_cnt:
  - +1 each cycle that local is valid and not granted (including cycles where slot_free=0), saturating at 15.
  - Cleared on a local grant.
  - Cleared when local valid is 0.
- Requesters must hold valid and data stable until accepted. The arbiter never grants a requester whose valid is 0.
- Simultaneous out_ready and new grant in HOLD: the old word completes and the new word replaces it in the same edge, with no bubble.

Optional Feature:
- Macro: LINK_ARB_STATS_EN.
- Defined: three CNT_W saturating counters, one per requester. Each increments on that requester's transfer, clears on reset, and is exposed on stat_grants with slice i = requester i.
- Undefined: no counters are synthesised and stat_grants is tied to 0. Arbitration is cycle-identical in both builds.

Decomposition:
- Shared package ring_pkg:
  - Source tag constants SRC_LEFT=2'b00, SRC_LOCAL=2'b01, SRC_RIGHT=2'b10.
  - DATA_W default.
  - Arbiter state encoding ARB_IDLE / ARB_HOLD.
- One sub-module: ring_starve_counter. It is a saturating wait counter with inc, clr and a ">= limit" flag, parameterised by the limit.

Test Plan:
- Reset then idle: reset=1 for 2 cycles with all req_valid=1 -> req_ready=000, out_valid=0. First cycle after release -> req_ready=001 (left, rr_ptr=0).
- Transit round-robin: left and right valid continuously, out_ready=1, data 0xA0000001 / 0xC0000002 -> out_src alternates 00,10,00,10 each cycle with no bubbles.
- Starvation: left, right and local all valid, out_ready=1, STARVE_LIMIT=4 -> local granted on the 5th cycle (out_src=01 one cycle later). wait_cnt then reads 0 and transit alternation resumes.
- Backpressure: out_ready=0 for 3 cycles with a word 0x12345678 held -> out_data stable, req_ready=000. With local valid during the stall, wait_cnt increments 3 times.
- Reset mid-HOLD: out_valid=1, out_ready=0, assert reset for 1 cycle -> out_valid=0, out_src=00, rr_ptr back to left.
- Stats (LINK_ARB_STATS_EN): 5 left, 3 local and 2 right transfers -> stat_grants slices read 5, 3, 2. Without the macro -> all 0.

Source files
------------

// File: rtl/ring_pkg.sv
// Shared ring-node definitions: source tags, default instruction width and
// the link arbiter state encoding.
package ring_pkg;

    localparam int RING_DATA_W = 32;

    localparam logic [1:0] SRC_LEFT  = 2'b00;
    localparam logic [1:0] SRC_LOCAL = 2'b01;
    localparam logic [1:0] SRC_RIGHT = 2'b10;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_t;

endpackage

// File: rtl/ring_starve_counter.sv
// Saturating wait counter for the local requester. Counts cycles spent valid
// but ungranted; raises at_limit once the count reaches LIMIT.
module ring_starve_counter #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [3:0] LIM     = 4'(LIMIT);
    localparam logic [3:0] CNT_MAX = 4'd15;

    logic [3:0] cnt;

    // Clear dominates; otherwise count up and hold at the 4-bit ceiling.
    always_ff @(posedge clk) begin
        if (reset || clr)
            cnt <= '0;
        else if (inc && (cnt != CNT_MAX))
            cnt <= cnt + 4'd1;
    end

    assign at_limit = (cnt >= LIM);

endmodule

// File: rtl/ring_link_arbiter.sv
// Outgoing ring link arbiter: left transit (0), local (1), right transit (2).
// Transits round-robin, local is forced through after STARVE_LIMIT waits.
// Optional grant statistics are built when LINK_ARB_STATS_EN is defined.
module ring_link_arbiter
    import ring_pkg::*;
#(
    parameter int DATA_W       = RING_DATA_W,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            req_valid,
    input  logic [3*DATA_W-1:0]   req_data,
    output logic [2:0]            req_ready,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic [1:0]            out_src,
    input  logic                  out_ready,
    output logic [3*CNT_W-1:0]    stat_grants
);

    arb_state_t        state_q, state_d;
    logic              rr_ptr;
    logic              starved;
    logic              slot_free;
    logic              any_grant;
    logic [2:0]        grant;
    logic [DATA_W-1:0] sel_data;
    logic [1:0]        sel_src;
    logic [DATA_W-1:0] data_p1;
    logic [1:0]        src_p1;

    assign slot_free = (state_q == ARB_IDLE) || out_ready;
    assign any_grant = |grant;
    assign req_ready = grant;

    ring_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .inc      (req_valid[1] && !grant[1]),
        .clr      (!req_valid[1] || grant[1]),
        .at_limit (starved)
    );

    // Grant selection: starved local, then round-robin transit, then local.
    always_comb begin
        grant = 3'b000;
        if (!reset && slot_free) begin
            if (req_valid[1] && starved)
                grant = 3'b010;
            else if (req_valid[0] || req_valid[2]) begin
                if (!rr_ptr)
                    grant = req_valid[0] ? 3'b001 : 3'b100;
                else
                    grant = req_valid[2] ? 3'b100 : 3'b001;
            end else if (req_valid[1])
                grant = 3'b010;
        end
    end

    // Mux the winner's word and tag toward the link register.
    always_comb begin
        sel_data = req_data[0 +: DATA_W];
        sel_src  = SRC_LEFT;
        if (grant[1]) begin
            sel_data = req_data[DATA_W +: DATA_W];
            sel_src  = SRC_LOCAL;
        end else if (grant[2]) begin
            sel_data = req_data[2*DATA_W +: DATA_W];
            sel_src  = SRC_RIGHT;
        end
    end

    // ---- stage p1: link register, loads whenever a grant fires ----
    always_ff @(posedge clk) begin
        if (reset) begin
            data_p1 <= '0;
            src_p1  <= SRC_LEFT;
        end else if (any_grant) begin
            data_p1 <= sel_data;
            src_p1  <= sel_src;
        end
    end

    // Round-robin pointer points away from the transit just served.
    always_ff @(posedge clk) begin
        if (reset)
            rr_ptr <= 1'b0;
        else if (grant[0])
            rr_ptr <= 1'b1;
        else if (grant[2])
            rr_ptr <= 1'b0;
    end

    // Link state register.
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= ARB_IDLE;
        else
            state_q <= state_d;
    end

    // Next state: a grant always lands in HOLD; a stalled HOLD stays put.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: if (any_grant) state_d = ARB_HOLD;
            ARB_HOLD: if (out_ready) state_d = any_grant ? ARB_HOLD : ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    assign out_valid = (state_q == ARB_HOLD);
    assign out_data  = data_p1;
    assign out_src   = src_p1;

`ifdef LINK_ARB_STATS_EN
    logic [CNT_W-1:0] stat_q [3];

    // Per-requester saturating transfer counters.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (reset)
                stat_q[i] <= '0;
            else if (grant[i] && (stat_q[i] != {CNT_W{1'b1}}))
                stat_q[i] <= stat_q[i] + 1'b1;
        end
    end

    assign stat_grants = {stat_q[2], stat_q[1], stat_q[0]};
`else
    assign stat_grants = '0;
`endif

endmodule
